simplex_dispense: RTL

SIMPLEX_DISPENSE -- requirements
Module: simplex_dispense

---
 rtl/simplex_dispense_if.sv | 22 ++
 rtl/simplex_dispense.sv | 120 ++++++++++++
 2 files changed

// File: rtl/simplex_dispense_if.sv
// Request/acknowledge/drive bundle between the vending controller and its host.
interface simplex_dispense_if;
  logic pi_cola;
  logic pi_money;
  logic pi_cola_ack;
  logic pi_coin_ack;
  logic po_cola_drv;
  logic po_coin_drv;
  logic po_busy;
  logic po_overflow;
  logic po_fault;

  modport slave (
    input  pi_cola, pi_money, pi_cola_ack, pi_coin_ack,
    output po_cola_drv, po_coin_drv, po_busy, po_overflow, po_fault
  );

  modport master (
    output pi_cola, pi_money, pi_cola_ack, pi_coin_ack,
    input  po_cola_drv, po_coin_drv, po_busy, po_overflow, po_fault
  );
endinterface

// File: rtl/simplex_dispense.sv
// Cola / change dispenser: queues requests in saturating counters and runs one
// actuator at a time with ack, timeout and an inter-actuation gap.
module simplex_dispense #(
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 4
) (
  input logic               sys_clk,
  input logic               sys_rst,
  simplex_dispense_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    DRV_COLA = 5'b00010,
    DRV_COIN = 5'b00100,
    WAIT_GAP = 5'b01000,
    FAULT    = 5'b10000
  } state_t;

  state_t         state;
  logic [1:0]     cola_cnt, coin_cnt;
  logic [1:0]     cola_nxt, coin_nxt;
  logic [CW-1:0]  cyc;
  logic [GW-1:0]  gap;
  logic           cola_drv, coin_drv, overflow, fault;
  logic           cola_req, coin_req, cola_deq, coin_deq;
  logic           cola_ovf, coin_ovf, cyc_last;

  // In FAULT the queues are frozen, so requests are dropped without counting
  // as overflow.
  always_comb begin
    cola_req = bus.pi_cola  && (state != FAULT);
    coin_req = bus.pi_money && (state != FAULT);
    cola_deq = (state == DRV_COLA) && bus.pi_cola_ack;
    coin_deq = (state == DRV_COIN) && bus.pi_coin_ack;
    cola_ovf = cola_req && !cola_deq && (cola_cnt == 2'd3);
    coin_ovf = coin_req && !coin_deq && (coin_cnt == 2'd3);
    cyc_last = (cyc == CW'(TIMEOUT - 1));

    cola_nxt = cola_cnt;
    case ({cola_req, cola_deq})
      2'b10:   if (cola_cnt != 2'd3) cola_nxt = cola_cnt + 2'd1;
      2'b01:   cola_nxt = cola_cnt - 2'd1;
      default: cola_nxt = cola_cnt;
    endcase

    coin_nxt = coin_cnt;
    case ({coin_req, coin_deq})
      2'b10:   if (coin_cnt != 2'd3) coin_nxt = coin_cnt + 2'd1;
      2'b01:   coin_nxt = coin_cnt - 2'd1;
      default: coin_nxt = coin_cnt;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      cola_cnt <= 2'd0;
      coin_cnt <= 2'd0;
      cyc      <= '0;
      gap      <= '0;
      cola_drv <= 1'b0;
      coin_drv <= 1'b0;
      overflow <= 1'b0;
      fault    <= 1'b0;
    end else begin
      cola_cnt <= cola_nxt;
      coin_cnt <= coin_nxt;
      overflow <= overflow | cola_ovf | coin_ovf;
      case (state)
        IDLE: begin
          cyc <= '0;
          if (cola_cnt != 2'd0) begin
            state    <= DRV_COLA;
            cola_drv <= 1'b1;
          end else if (coin_cnt != 2'd0) begin
            state    <= DRV_COIN;
            coin_drv <= 1'b1;
          end
        end
        DRV_COLA, DRV_COIN: begin
          // Ack on the final allowed cycle still wins over the timeout.
          if (cola_deq || coin_deq) begin
            state    <= WAIT_GAP;
            cola_drv <= 1'b0;
            coin_drv <= 1'b0;
            gap      <= '0;
          end else if (cyc_last) begin
            state    <= FAULT;
            cola_drv <= 1'b0;
            coin_drv <= 1'b0;
            fault    <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        WAIT_GAP: begin
          if (gap == GW'(GAP - 1)) state <= IDLE;
          else                     gap   <= gap + GW'(1);
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state    <= IDLE;
          cola_drv <= 1'b0;
          coin_drv <= 1'b0;
        end
      endcase
    end
  end

  assign bus.po_cola_drv = cola_drv;
  assign bus.po_coin_drv = coin_drv;
  assign bus.po_overflow = overflow;
  assign bus.po_fault    = fault;
  assign bus.po_busy     = (state != IDLE) || (cola_cnt != 2'd0) || (coin_cnt != 2'd0);
endmodule
